// File: rtl/cla_pkg.sv
// Shared types and default sizes for the carry lookahead adder and the
// accumulator built on top of it.
package cla_pkg;

    localparam int CLA_WIDTH   = 16;
    localparam int CLA_COUNT_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } cla_acc_state_t;

endpackage

// File: rtl/carry_lookahead_adder.sv
// Unsigned WIDTH-bit adder with carry-out, carries formed by a parallel-prefix
// (Kogge-Stone) generate/propagate network rather than a ripple chain.
module carry_lookahead_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = CLA_WIDTH
) (
    input  logic [WIDTH-1:0] i_add1,
    input  logic [WIDTH-1:0] i_add2,
    output logic [WIDTH:0]   o_result
);

    // gk/pk end up holding the group generate/propagate from bit 0 up to
    // each bit position, so gk[i] is the carry out of bit i.
    always_comb begin
        logic [WIDTH-1:0] p_sum;
        logic [WIDTH-1:0] gk;
        logic [WIDTH-1:0] pk;
        logic [WIDTH-1:0] gn;
        logic [WIDTH-1:0] pn;
        p_sum = i_add1 ^ i_add2;
        gk    = i_add1 & i_add2;
        pk    = p_sum;
        for (int d = 1; d < WIDTH; d = d * 2) begin
            gn = gk;
            pn = pk;
            for (int i = d; i < WIDTH; i++) begin
                gn[i] = gk[i] | (pk[i] & gk[i-d]);
                pn[i] = pk[i] & pk[i-d];
            end
            gk = gn;
            pk = pn;
        end
        o_result        = '0;
        o_result[0]     = p_sum[0];
        for (int i = 1; i < WIDTH; i++) begin
            o_result[i] = p_sum[i] ^ gk[i-1];
        end
        o_result[WIDTH] = gk[WIDTH-1];
    end

endmodule

// File: rtl/cla_accumulator.sv
// Burst accumulator: sums i_len streamed operands through one lookahead adder,
// tracks a sticky carry-out flag and holds the result until it is consumed.
module cla_accumulator
    import cla_pkg::*;
#(
    parameter int WIDTH   = CLA_WIDTH,
    parameter int COUNT_W = CLA_COUNT_W
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic [COUNT_W-1:0] i_len,
    input  logic               i_valid,
    input  logic [WIDTH-1:0]   i_operand,
    output logic               o_ready,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [WIDTH-1:0]   o_sum,
    output logic               o_overflow,
    output logic               o_busy
);

    cla_acc_state_t     state;
    logic [WIDTH-1:0]   acc;
    logic               ovf;
    logic [COUNT_W-1:0] remaining;
    logic [WIDTH:0]     add_result;

    carry_lookahead_adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .i_add1   (acc),
        .i_add2   (i_operand),
        .o_result (add_result)
    );

    // Handshake outputs are registered alongside the state so they never
    // see a combinational path from the inputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            acc       <= '0;
            ovf       <= 1'b0;
            remaining <= '0;
            o_ready   <= 1'b0;
            o_valid   <= 1'b0;
            o_busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        acc       <= '0;
                        ovf       <= 1'b0;
                        remaining <= i_len;
                        o_busy    <= 1'b1;
                        if (i_len != '0) begin
                            state   <= ACCUM;
                            o_ready <= 1'b1;
                        end else begin
                            state   <= HOLD;
                            o_valid <= 1'b1;
                        end
                    end
                end
                ACCUM: begin
                    if (i_valid) begin
                        acc       <= add_result[WIDTH-1:0];
                        ovf       <= ovf | add_result[WIDTH];
                        remaining <= remaining - COUNT_W'(1);
                        if (remaining == COUNT_W'(1)) begin
                            state   <= HOLD;
                            o_ready <= 1'b0;
                            o_valid <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (i_ready) begin
                        state   <= IDLE;
                        o_valid <= 1'b0;
                        o_busy  <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    o_ready <= 1'b0;
                    o_valid <= 1'b0;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_sum      = acc;
    assign o_overflow = ovf;

endmodule

// File: tb/tb_cla_accumulator.sv
// Directed and randomized bursts against an arithmetic model: the expected sum
// is the plain integer total mod 2^WIDTH, overflow is "total reached 2^WIDTH".
module tb_cla_accumulator;
    import cla_pkg::*;

    localparam int W  = CLA_WIDTH;
    localparam int CW = CLA_COUNT_W;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [CW-1:0] len;
    logic          valid;
    logic [W-1:0]  operand;
    logic          ready_in;
    logic          o_ready;
    logic          o_valid;
    logic [W-1:0]  o_sum;
    logic          o_overflow;
    logic          o_busy;

    int errors = 0;
    int checks = 0;
    logic [W-1:0] ops[$];

    cla_accumulator #(
        .WIDTH   (W),
        .COUNT_W (CW)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (start),
        .i_len      (len),
        .i_valid    (valid),
        .i_operand  (operand),
        .o_ready    (o_ready),
        .o_valid    (o_valid),
        .i_ready    (ready_in),
        .o_sum      (o_sum),
        .o_overflow (o_overflow),
        .o_busy     (o_busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Runs one burst of n operands taken from ops, then holds the result for
    // holdCycles cycles before consuming it.
    task automatic applyStimulus(input string name, input int n, input bit gaps,
                                 input int holdCycles, input bit startInHold);
        longint       total = 0;
        int           beats = 0;
        int           cycles = 0;
        logic [W-1:0] expSum;
        logic         expOvf;
        for (int i = 0; i < n; i++) total += longint'(ops[i]);
        expSum = W'(total);
        expOvf = (total >= (longint'(1) << W));

        start   = 1'b1;
        len     = CW'(n);
        valid   = 1'b1;
        operand = W'($urandom);
        tick();
        start = 1'b0;
        valid = 1'b0;

        while (beats < n && cycles < 20 * n + 20) begin
            valid   = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            operand = valid ? ops[beats] : W'($urandom);
            checkOutput({name, "_ready_during"}, 32'(o_ready), 1);
            tick();
            if (valid) beats++;
            cycles++;
        end
        valid = 1'b0;
        checkOutput({name, "_beats"}, beats, n);
        checkOutput({name, "_ready_after"}, 32'(o_ready), 0);
        checkOutput({name, "_valid"}, 32'(o_valid), 1);
        checkOutput({name, "_busy"}, 32'(o_busy), 1);
        checkOutput({name, "_sum"}, 32'(o_sum), 32'(expSum));
        checkOutput({name, "_ovf"}, 32'(o_overflow), 32'(expOvf));

        for (int c = 0; c < holdCycles; c++) begin
            if (startInHold && c == 1) begin
                start = 1'b1;
                len   = CW'(3);
            end
            tick();
            start = 1'b0;
            checkOutput({name, "_hold_valid"}, 32'(o_valid), 1);
            checkOutput({name, "_hold_sum"}, 32'(o_sum), 32'(expSum));
            checkOutput({name, "_hold_ovf"}, 32'(o_overflow), 32'(expOvf));
        end

        ready_in = 1'b1;
        tick();
        ready_in = 1'b0;
        checkOutput({name, "_idle_valid"}, 32'(o_valid), 0);
        checkOutput({name, "_idle_busy"}, 32'(o_busy), 0);
        checkOutput({name, "_idle_ready"}, 32'(o_ready), 0);
        checkOutput({name, "_idle_sum"}, 32'(o_sum), 32'(expSum));
        checkOutput({name, "_idle_ovf"}, 32'(o_overflow), 32'(expOvf));
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        len      = '0;
        valid    = 1'b0;
        operand  = '0;
        ready_in = 1'b0;
        tick();
        tick();
        checkOutput("reset_ready", 32'(o_ready), 0);
        checkOutput("reset_valid", 32'(o_valid), 0);
        checkOutput("reset_sum", 32'(o_sum), 0);
        checkOutput("reset_ovf", 32'(o_overflow), 0);
        checkOutput("reset_busy", 32'(o_busy), 0);
        rst = 1'b0;
        tick();

        $display("[TB] basic burst");
        ops = '{16'd100, 16'd200, 16'd300};
        applyStimulus("basic", 3, 1'b0, 0, 1'b0);

        $display("[TB] overflow burst then clean burst");
        ops = '{16'd65535, 16'd1};
        applyStimulus("ovf", 2, 1'b0, 1, 1'b0);
        ops = '{16'd5};
        applyStimulus("after_ovf", 1, 1'b0, 0, 1'b0);

        $display("[TB] zero-length burst");
        ops.delete();
        applyStimulus("zero", 0, 1'b0, 1, 1'b0);

        $display("[TB] backpressure burst");
        ops = '{16'd10, 16'd20, 16'd30, 16'd40};
        applyStimulus("bp", 4, 1'b1, 5, 1'b1);

        $display("[TB] reset mid-burst");
        start = 1'b1;
        len   = CW'(4);
        tick();
        start   = 1'b0;
        valid   = 1'b1;
        operand = 16'd11;
        tick();
        operand = 16'd22;
        tick();
        rst     = 1'b1;
        operand = 16'd33;
        tick();
        rst   = 1'b0;
        valid = 1'b0;
        checkOutput("midrst_ready", 32'(o_ready), 0);
        checkOutput("midrst_valid", 32'(o_valid), 0);
        checkOutput("midrst_sum", 32'(o_sum), 0);
        checkOutput("midrst_ovf", 32'(o_overflow), 0);
        checkOutput("midrst_busy", 32'(o_busy), 0);
        tick();
        ops = '{16'd7};
        applyStimulus("post_rst", 1, 1'b0, 0, 1'b0);

        $display("[TB] long burst");
        ops.delete();
        for (int i = 0; i < 255; i++) ops.push_back(16'd1);
        applyStimulus("long", 255, 1'b0, 0, 1'b0);

        $display("[TB] random bursts");
        for (int r = 0; r < 6; r++) begin
            int n;
            n = $urandom_range(1, 12);
            ops.delete();
            for (int i = 0; i < n; i++) ops.push_back(W'($urandom));
            applyStimulus("rand", n, 1'b1, $urandom_range(0, 3), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
